// File: rtl/bin2bcd_pkg.sv
// Shared constants for the sequential double-dabble binary-to-BCD converter.
// State encoding and the per-nibble add-3 adjust thresholds live here.
package bin2bcd_pkg;

  typedef logic state_t;

  localparam state_t ST_IDLE  = 1'b0;
  localparam state_t ST_SHIFT = 1'b1;

  localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
  localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

endpackage

// File: rtl/bcd_nibble_adj.sv
// Combinational double-dabble adjust for one BCD nibble: adds 3 when the
// nibble is 5 or more, so the following left shift carries into the next digit.
module bcd_nibble_adj
  import bin2bcd_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [3:0] nib_o
);

  // Inputs are at most 9 during a legal conversion, so the sum stays in 4 bits.
  assign nib_o = (nib_i >= BCD_ADJ_THRESH) ? (nib_i + BCD_ADJ_ADD) : nib_i;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary-to-BCD converter with a start/done handshake.
// Optional leading-zero blank mask enabled by defining BIN2BCD_BLANK_EN.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 10,
  parameter int CNT_W  = 6
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic                  valid,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [DIGITS-1:0]     blank_mask
);

  // Handshake: start is sampled on a rising edge and accepted only while
  // busy is low (IDLE); bin_in is captured on that edge alone. done is a
  // one-cycle pulse in the cycle bcd_out/valid first show the new result,
  // and bcd_out/valid hold steady until the next done pulse.

  state_t                 state_q, state_d;
  logic [WIDTH-1:0]       shreg_q, shreg_d;
  logic [4*DIGITS-1:0]    scratch_q, scratch_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [4*DIGITS-1:0]    bcd_q, bcd_d;
  logic                   valid_q, valid_d;
  logic                   done_q, done_d;

  logic [4*DIGITS-1:0]    scratch_adj;
  logic [4*DIGITS-1:0]    scratch_sh;
  logic [WIDTH-1:0]       shreg_sh;
  logic                   last_shift;
  logic                   scratch_msb_unused;

  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_adj
      bcd_nibble_adj u_adj (
        .nib_i (scratch_q[4*g +: 4]),
        .nib_o (scratch_adj[4*g +: 4])
      );
    end
  endgenerate

  // Adjust first, then shift {scratch, shreg} left by one as a single vector.
  assign scratch_sh         = {scratch_adj[4*DIGITS-2:0], shreg_q[WIDTH-1]};
  assign shreg_sh           = {shreg_q[WIDTH-2:0], 1'b0};
  assign last_shift         = (cnt_q == CNT_W'(WIDTH - 1));
  assign scratch_msb_unused = scratch_adj[4*DIGITS-1];

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start)      state_d = ST_SHIFT;
      ST_SHIFT: if (last_shift) state_d = ST_IDLE;
      default:                  state_d = ST_IDLE;
    endcase
  end

  // FSM / handshake outputs
  always_comb begin
    busy    = (state_q == ST_SHIFT);
    done    = done_q;
    valid   = valid_q;
    bcd_out = bcd_q;
  end

  // Datapath next-state
  always_comb begin
    shreg_d   = shreg_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    bcd_d     = bcd_q;
    valid_d   = valid_q;
    done_d    = 1'b0;
    if (state_q == ST_IDLE) begin
      if (start) begin
        shreg_d   = bin_in;
        scratch_d = '0;
        cnt_d     = '0;
      end
    end else begin
      shreg_d   = shreg_sh;
      scratch_d = scratch_sh;
      cnt_d     = cnt_q + CNT_W'(1);
      if (last_shift) begin
        bcd_d   = scratch_sh;
        valid_d = 1'b1;
        done_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shreg_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      bcd_q     <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      shreg_q   <= shreg_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      bcd_q     <= bcd_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
    end
  end

`ifdef BIN2BCD_BLANK_EN
  logic [DIGITS-1:0] blank_q, blank_d;
  logic              all_zero;

  // Bit i is set when digit i and every higher digit are zero; digit 0 always shows.
  always_comb begin
    blank_d  = '0;
    all_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      all_zero   = all_zero & (scratch_sh[4*i +: 4] == 4'd0);
      blank_d[i] = all_zero;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blank_q <= '0;
    end else if (done_d) begin
      blank_q <= blank_d;
    end
  end

  assign blank_mask = blank_q;
`else
  assign blank_mask = '0;
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: directed vectors, scoreboard queues,
// and a negedge monitor that checks every done pulse and output stability.
module tb_bin2bcd_seq;

  localparam int WIDTH  = 32;
  localparam int DIGITS = 10;
  localparam int CNT_W  = 6;
  localparam int LAT    = 32;

`ifdef BIN2BCD_BLANK_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif

  logic                clk;
  logic                reset_n;
  logic                start;
  logic [WIDTH-1:0]    bin_in;
  logic                busy;
  logic                done;
  logic                valid;
  logic [4*DIGITS-1:0] bcd_out;
  logic [DIGITS-1:0]   blank_mask;

  logic [4*DIGITS-1:0] exp_q[$];
  logic [DIGITS-1:0]   msk_q[$];
  int                  acc_q[$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [4*DIGITS-1:0] last_bcd;
  logic [DIGITS-1:0]   last_msk;

  bin2bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .bin_in     (bin_in),
    .busy       (busy),
    .done       (done),
    .valid      (valid),
    .bcd_out    (bcd_out),
    .blank_mask (blank_mask)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DIGITS-1:0] exp_mask(input logic [DIGITS-1:0] m);
    return BLANK_EN ? m : '0;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [WIDTH-1:0] val, input logic [4*DIGITS-1:0] exp,
                       input logic [DIGITS-1:0] msk);
    @(negedge clk);
    bin_in = val;
    start  = 1'b1;
    exp_q.push_back(exp);
    msk_q.push_back(exp_mask(msk));
    @(posedge clk);
    acc_q.push_back(cyc + 1);
    #1 start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      check("idle_timeout", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
      msk_q.delete();
      acc_q.delete();
    end
    @(posedge clk);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (reset_n && done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        logic [4*DIGITS-1:0] e;
        logic [DIGITS-1:0]   m;
        int                  a;
        e = exp_q.pop_front();
        m = msk_q.pop_front();
        a = acc_q.pop_front();
        check("bcd_out", 64'(bcd_out), 64'(e));
        check("blank_mask", 64'(blank_mask), 64'(m));
        check("valid_at_done", 64'(valid), 64'd1);
        check("busy_at_done", 64'(busy), 64'd0);
        check("latency", 64'(cyc - a), 64'(LAT));
      end
      last_bcd = bcd_out;
      last_msk = blank_mask;
    end else if (reset_n && valid) begin
      check("bcd_stable", 64'(bcd_out), 64'(last_bcd));
      check("mask_stable", 64'(blank_mask), 64'(last_msk));
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    reset_n = 1'b0;
    start   = 1'b0;
    bin_in  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_valid", 64'(valid), 64'd0);
    check("rst_bcd", 64'(bcd_out), 64'd0);
    check("rst_mask", 64'(blank_mask), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    issue(32'd0, 40'h00_0000_0000, 10'b1111111110);
    wait_idle();
    issue(32'd12345678, 40'h00_1234_5678, 10'b1100000000);
    wait_idle();
    issue(32'hFFFF_FFFF, 40'h42_9496_7295, 10'b0000000000);
    wait_idle();
    issue(32'd305, 40'h00_0000_0305, 10'b1111111000);
    wait_idle();

    // Back-to-back with start held high: restart is accepted in the done cycle.
    @(negedge clk);
    bin_in = 32'd55;
    start  = 1'b1;
    exp_q.push_back(40'h55);
    msk_q.push_back(exp_mask(10'b1111111100));
    @(posedge clk);
    acc_q.push_back(cyc + 1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 60);
    if (!done) check("b2b_done_timeout", 64'd0, 64'd1);
    bin_in = 32'd89;
    exp_q.push_back(40'h89);
    msk_q.push_back(exp_mask(10'b1111111100));
    @(posedge clk);
    acc_q.push_back(cyc + 1);
    #1 start = 1'b0;
    wait_idle();

    // Start while busy (bin_in changed) must be ignored.
    issue(32'd1000, 40'h1000, 10'b1111110000);
    repeat (10) @(posedge clk);
    #1;
    bin_in = 32'd7;
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_idle();

    // Reset mid-conversion aborts with no done.
    issue(32'd999, 40'h999, 10'b1111111000);
    repeat (15) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_valid", 64'(valid), 64'd0);
    check("abort_bcd", 64'(bcd_out), 64'd0);
    check("abort_mask", 64'(blank_mask), 64'd0);
    void'(exp_q.pop_back());
    void'(msk_q.pop_back());
    void'(acc_q.pop_back());
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    issue(32'd144, 40'h144, 10'b1111111000);
    wait_idle();

    repeat (40) @(posedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
